// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state
// type and default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: produces the 64-bit {hi,lo} result for MULT/MULTU/
// DIV/DIVU and flags a divide by zero.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_b_safe;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] a_ext;
  logic [63:0] b_ext;

  // Signed division runs on magnitudes; 0x80000000 / -1 falls out naturally
  // because the negated quotient wraps back to 0x80000000.
  always_comb begin
    signed_div  = (op == MD_DIV);
    a_mag       = rs[31] ? (32'd0 - rs) : rs;
    b_mag       = rt[31] ? (32'd0 - rt) : rt;
    div_a       = signed_div ? a_mag : rs;
    div_b       = signed_div ? b_mag : rt;
    div_by_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (rt == 32'd0);
    div_b_safe  = (div_b == 32'd0) ? 32'd1 : div_b;
    quot        = div_a / div_b_safe;
    rem         = div_a % div_b_safe;
    if (signed_div && (rs[31] ^ rt[31])) begin
      quot = 32'd0 - quot;
    end
    if (signed_div && rs[31]) begin
      rem = 32'd0 - rem;
    end

    a_ext = (op == MD_MULT) ? {{32{rs[31]}}, rs} : {32'd0, rs};
    b_ext = (op == MD_MULT) ? {{32{rt[31]}}, rt} : {32'd0, rt};

    result = 64'd0;
    case (op)
      MD_MULT, MD_MULTU: result = a_ext * b_ext;
      MD_DIV, MD_DIVU:   result = {rem, quot};
      default:           result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, the IDLE/RUN FSM and the latency counter.
// Results are captured at issue and committed when the counter expires.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_commit;
  logic [63:0]      calc_result;
  logic             div_by_zero;

  md_calc u_calc (
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .result      (calc_result),
    .div_by_zero (div_by_zero)
  );

  // A divide by zero still occupies the unit for the full latency but
  // leaves HI/LO untouched, hence the separate commit flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      counter     <= '0;
      pend_hi     <= 32'd0;
      pend_lo     <= 32'd0;
      pend_commit <= 1'b0;
      busy        <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                pend_hi     <= calc_result[63:32];
                pend_lo     <= calc_result[31:0];
                pend_commit <= 1'b1;
                counter     <= MULT_LOAD;
                busy        <= 1'b1;
                state       <= RUN;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi     <= calc_result[63:32];
                pend_lo     <= calc_result[31:0];
                pend_commit <= !div_by_zero;
                counter     <= DIV_LOAD;
                busy        <= 1'b1;
                state       <= RUN;
              end
              MD_MTHI: hi <= rs;
              MD_MTLO: lo <= rs;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (counter == CNT_ONE) begin
            if (pend_commit) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            counter <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            counter <= counter - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Randomised scoreboard bench for md_unit: a reference model predicts HI/LO and
// busy length for each accepted op; a monitor checks them when busy falls.
module tb_md_unit;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [31:0] new_hi;
    logic [31:0] new_lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          cycles;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t        sb[$];
  int          n_cmp      = 0;
  int          n_bad      = 0;
  int          edge_cnt   = 0;
  int          busy_until = 0;
  int          busy_cnt   = 0;
  logic        prev_busy  = 1'b0;
  logic [31:0] model_hi   = 32'd0;
  logic [31:0] model_lo   = 32'd0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Accepted ops follow the architectural rules: an issue is taken only once
  // the previous op's latency window has fully elapsed.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int                t;
    bit                mt;
    exp_t              e;
    int                sa;
    int                sbv;
    longint            p;
    longint unsigned   ua;
    longint unsigned   ub;
    longint unsigned   pu;
    t  = edge_cnt + 1;
    mt = 1'b0;
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    if (t > busy_until) begin
      e.old_hi = model_hi;
      e.old_lo = model_lo;
      e.new_hi = model_hi;
      e.new_lo = model_lo;
      e.cycles = 0;
      sa  = a;
      sbv = b;
      case (o)
        MD_MULT: begin
          p = longint'(sa) * longint'(sbv);
          e.new_hi = p[63:32];
          e.new_lo = p[31:0];
          e.cycles = MULT_N;
        end
        MD_MULTU: begin
          ua = a;
          ub = b;
          pu = ua * ub;
          e.new_hi = pu[63:32];
          e.new_lo = pu[31:0];
          e.cycles = MULT_N;
        end
        MD_DIV: begin
          e.cycles = DIV_N;
          if (b != 32'd0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              e.new_lo = 32'h8000_0000;
              e.new_hi = 32'd0;
            end else begin
              e.new_lo = sa / sbv;
              e.new_hi = sa % sbv;
            end
          end
        end
        MD_DIVU: begin
          e.cycles = DIV_N;
          if (b != 32'd0) begin
            e.new_lo = a / b;
            e.new_hi = a % b;
          end
        end
        MD_MTHI: begin
          model_hi = a;
          mt = 1'b1;
        end
        MD_MTLO: begin
          model_lo = a;
          mt = 1'b1;
        end
        default: ;
      endcase
      if (e.cycles > 0) begin
        sb.push_back(e);
        model_hi   = e.new_hi;
        model_lo   = e.new_lo;
        busy_until = t + e.cycles;
      end
    end
    @(negedge clk);
    start = 1'b0;
    op    = MD_NOP;
    if (mt) begin
      checkOutput("mt_hi", hi, model_hi);
      checkOutput("mt_lo", lo, model_lo);
    end
  endtask

  task automatic waitIdle();
    while (edge_cnt + 1 <= busy_until) @(negedge clk);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: HI/LO must hold pre-op values while busy, and the final values
  // plus busy length are checked on the cycle busy drops.
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (sb.size() > 0) begin
          checkOutput("hold_hi", hi, sb[0].old_hi);
          checkOutput("hold_lo", lo, sb[0].old_lo);
        end else begin
          checkOutput("unexpected_busy", {31'd0, busy}, 32'd0);
        end
      end else if (prev_busy) begin
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("result_hi", hi, e.new_hi);
          checkOutput("result_lo", lo, e.new_lo);
          checkOutput("busy_len", 32'(busy_cnt), 32'(e.cycles));
        end else begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    start = 1'b0;
    op    = MD_NOP;
    rs    = 32'd0;
    rt    = 32'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    busy_until = edge_cnt;
    @(negedge clk);

    applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    waitIdle();
    applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    waitIdle();
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    waitIdle();
    applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0);
    applyStimulus(MD_DIVU, 32'd7, 32'd0);
    waitIdle();
    applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle();

    applyStimulus(MD_DIV, 32'd1000, 32'd7);
    repeat (2) @(negedge clk);
    applyStimulus(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    waitIdle();
    applyStimulus(MD_MULT, 32'h0001_2345, 32'hFFFF_0001);
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    waitIdle();

    for (int i = 0; i < 60; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    waitIdle();

    applyStimulus(MD_MULT, 32'h0001_0003, 32'h0001_0005);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    sb.delete();
    model_hi   = 32'd0;
    model_lo   = 32'd0;
    busy_until = edge_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("post_abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("post_abort_hi", hi, 32'd0);
    checkOutput("post_abort_lo", lo, 32'd0);

    applyStimulus(MD_MULTU, 32'd6, 32'd7);
    waitIdle();
    @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("final_hi", hi, model_hi);
    checkOutput("final_lo", lo, model_lo);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multiply/divide unit for the pipelined MIPS core. It sits beside the EX stage and is consumed by the hazard unit (which reads busy) and by the MFHI/MFLO forwarding path (which reads hi and lo).
- Executes MULT, MULTU, DIV and DIVU with fixed multi-cycle latency.
- Executes MTHI and MTLO in a single cycle.
- Holds the architectural HI and LO registers.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle strobe from EX: issue op this cycle
op  input  3  operation code (encodings in md_pkg)
rs  input  32  operand A (dividend / multiplicand / MTHI-MTLO source)
rt  input  32  operand B (divisor / multiplier)
busy  output  1  operation in flight
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending regs=0. Takes effect immediately regardless of clk.
- Reset asserted mid-operation aborts the operation; no HI/LO commit after release.

Ops:
- MULT: signed 32x32->64, {hi,lo}=product.
- MULTU: unsigned 32x32->64, {hi,lo}=product.
- DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
- DIVU: unsigned quotient/remainder.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIV or DIVU with rt==0: hi and lo unchanged. busy still runs the full DIV_CYCLES.
- MTHI: hi<=rs at the edge where start=1. No busy.
- MTLO: lo<=rs at the edge where start=1. No busy.
- NOP or any undefined op code with start=1: ignored.

States:
- IDLE: busy=0.
  - start with a mult op at edge T: results are computed from rs/rt sampled at T into pend_hi/pend_lo; counter<=MULT_CYCLES; go to RUN.
  - start with a div op: same, with counter<=DIV_CYCLES.
- RUN: busy=1. counter decrements each edge.
  - At the edge where counter==1: hi<=pend_hi, lo<=pend_lo, busy<=0, return to IDLE.

Timing:
- For an op issued at edge T, busy is high in cycles T+1 .. T+N, where N is the latency parameter.
- New hi/lo values are visible from cycle T+N+1, i.e. in the same cycle busy falls.

Boundary rules:
- start while busy=1 (any op, including MTHI/MTLO): ignored. The hazard unit guarantees this never happens; the bench checks it anyway.
- Back-to-back issue: a start in the cycle busy falls is accepted, and busy rises again the next cycle.
- hi/lo hold their values throughout RUN. A read during RUN returns the pre-op values.
- Operand width: all internal products and quotients are computed at 64/32 bits; no truncation other than the hi/lo split.

Decomposition:
- md_pkg holds:
  - op encodings: MD_NOP=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6
  - the state typedef (IDLE, RUN)
  - default latency constants
- One sub-module is natural: md_calc. It is purely combinational: op/rs/rt -> 64-bit result plus a div_by_zero flag. md_unit owns the FSM, counter and registers.

Test Plan:
1. Release reset; MULT rs=0xFFFFFFFE rt=0x00000003 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. MULTU with the same operands -> after 5 cycles hi=0x00000002, lo=0xFFFFFFFA. Separately, DIV rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. MTHI rs=0x12345678, then DIVU rs=7 rt=0 -> busy 10 cycles; hi stays 0x12345678 and lo stays unchanged afterwards.
4. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
5. During a DIV, at cycle 3 of busy: pulse start with MTLO rs=0xDEADBEEF -> ignored; lo after completion is the quotient. Then issue MULT in the same cycle busy falls -> accepted, busy reasserts next cycle.
6. Drive reset=0 asynchronously (between clock edges) in cycle 4 of a MULT -> busy, hi and lo go to 0 immediately; after release they stay 0 with no late commit.
